// File: rtl/obi_match_engine.sv
// obi_match_engine: linear key search over a word buffer in memory.
// A run starts on a rising edge of the MMIO start level. The engine then
// reads NumWords words through a single-outstanding OBI read port and
// stops at the first word equal to the key. It reports done/match/index
// back to the MMIO block.
module obi_match_engine #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter int unsigned          NumWords  = 16,
  parameter int unsigned          IdxWidth  = $clog2(NumWords) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DataWidth-1:0]   key_i,
  output logic                   done_o,
  output logic                   match_o,
  output logic [IdxWidth-1:0]    match_idx_o,
  output logic                   busy_o,
  output logic                   mem_req_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumWords - 1);
  localparam logic [IdxWidth-1:0] MissIdx = IdxWidth'(NumWords);

  state_e               state_q;
  logic                 start_q;
  logic                 armed_q;
  logic                 start_edge;
  logic [IdxWidth-1:0]  cnt_q;
  logic [DataWidth-1:0] key_q;

  // Read-only port: write enable low, all byte lanes enabled.
  assign mem_we_o = 1'b0;
  assign mem_be_o = '1;

  // armed_q masks the first cycle after reset. If start is still high
  // when reset releases, start_q picks the level up without a launch.
  assign start_edge = start_i & ~start_q & armed_q;

  // Start level history for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      start_q <= start_i;
      armed_q <= 1'b1;
    end
  end

  // Search FSM. Every output is registered here. An rvalid is only
  // consumed in WAIT, so a late response after a reset is harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      done_o      <= 1'b0;
      match_o     <= 1'b0;
      match_idx_o <= '0;
      busy_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            key_q       <= key_i;
            cnt_q       <= '0;
            done_o      <= 1'b0;
            match_o     <= 1'b0;
            match_idx_o <= '0;
            busy_o      <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= BaseAddr;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // req/addr stay put until granted
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_rdata_i == key_q) begin
              match_o     <= 1'b1;
              match_idx_o <= cnt_q;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
              state_q     <= DONE;
            end else if (cnt_q == LastIdx) begin
              match_o     <= 1'b0;
              match_idx_o <= MissIdx;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
              state_q     <= DONE;
            end else begin
              // byte address of the next word; wraps modulo 2^AddrWidth
              cnt_q      <= cnt_q + 1'b1;
              mem_addr_o <= BaseAddr + (AddrWidth'(cnt_q + 1'b1) << 2);
              mem_req_o  <= 1'b1;
              state_q    <= REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_match_engine.sv
// Directed bench for obi_match_engine: a 16-word instance with a
// configurable-latency memory model and a 1-word instance.
module tb_obi_match_engine;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-word instance
  logic        start0, done0, match0, busy0, req0, we0, gnt0, rv0;
  logic [31:0] key0, addr0, rd0;
  logic [4:0]  idx0;
  logic [3:0]  be0;

  // 1-word instance
  logic        start1, done1, match1, busy1, req1, we1, gnt1, rv1;
  logic [31:0] key1, addr1, rd1;
  logic [0:0]  idx1;
  logic [3:0]  be1;

  obi_match_engine #(.BaseAddr(BASE), .NumWords(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .key_i(key0),
    .done_o(done0), .match_o(match0), .match_idx_o(idx0), .busy_o(busy0),
    .mem_req_o(req0), .mem_addr_o(addr0), .mem_we_o(we0), .mem_be_o(be0),
    .mem_gnt_i(gnt0), .mem_rvalid_i(rv0), .mem_rdata_i(rd0));

  obi_match_engine #(.BaseAddr(32'h0), .NumWords(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .key_i(key1),
    .done_o(done1), .match_o(match1), .match_idx_o(idx1), .busy_o(busy1),
    .mem_req_o(req1), .mem_addr_o(addr1), .mem_we_o(we1), .mem_be_o(be1),
    .mem_gnt_i(gnt1), .mem_rvalid_i(rv1), .mem_rdata_i(rd1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model for dut0 ----------------
  logic [31:0] mem [16];
  int gdly = 0, rdly = 0;
  int rd_cnt, seq_err, stall_err, ost_err, rv_seen;
  bit seen18;
  int g_cnt = 0, rv_cnt = 0, pend_idx = 0;
  bit pend = 0, req_pend = 0;
  logic [31:0] hold_addr = '0;

  initial begin
    gnt0 = 1'b0; rv0 = 1'b0; rd0 = '0;
    forever begin
      @(negedge clk);
      rv0 = 1'b0;
      if (pend) begin
        if (rv_cnt == 0) begin
          rv0 = 1'b1; rd0 = mem[pend_idx]; pend = 0; rv_seen++;
        end else rv_cnt--;
      end
      gnt0 = 1'b0;
      if (req_pend && (!req0 || addr0 != hold_addr)) stall_err++;
      req_pend = 0;
      if (req0) begin
        if (pend || rv0) ost_err++;
        if (g_cnt == gdly) begin
          gnt0 = 1'b1; g_cnt = 0;
          if (addr0 != BASE + 32'(4 * rd_cnt)) seq_err++;
          if (addr0 == BASE + 32'h18) seen18 = 1;
          pend_idx = int'((addr0 - BASE) >> 2) & 15;
          rd_cnt++; pend = 1; rv_cnt = rdly;
        end else begin
          g_cnt++; req_pend = 1; hold_addr = addr0;
        end
      end
    end
  end

  // ---------------- zero-wait memory model for dut1 ----------------
  logic [31:0] mem1w = '0;
  int rd1_cnt = 0;
  bit pend1 = 0;
  initial begin
    gnt1 = 1'b0; rv1 = 1'b0; rd1 = '0;
    forever begin
      @(negedge clk);
      rv1 = pend1; rd1 = mem1w; pend1 = 0;
      gnt1 = req1;
      if (req1) begin pend1 = 1; rd1_cnt++; end
    end
  end

  task automatic clr();
    rd_cnt = 0; seq_err = 0; stall_err = 0; ost_err = 0; seen18 = 0; rv_seen = 0;
  endtask

  // Launch a dut0 run; optional key change at cycle chg_at and a start
  // re-pulse at cycle e2 while busy. n = cycles from start to done.
  task automatic do_run(input logic [31:0] k, input int chg_at, input logic [31:0] k2,
                        input int e2, output int n);
    start0 = 1'b1; key0 = k; n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        chk("busy_after_edge", busy0, 1);
        chk("done_cleared", done0, 0);
      end
      if (n == chg_at) key0 = k2;
      if (n == e2) start0 = 1'b0;
      if (n == e2 + 1) start0 = 1'b1;
    end while (!done0 && n < 3000);
    if (!done0) chk("run_timeout", 0, 1);
  endtask

  task automatic run1(input logic [31:0] k, output int n);
    start1 = 1'b1; key1 = k; n = 0; rd1_cnt = 0;
    do begin @(posedge clk); #1; n++; end while (!done1 && n < 100);
    if (!done1) chk("run1_timeout", 0, 1);
    start1 = 1'b0;
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  int n, bad_out;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0; start0 = 1'b0; key0 = '0; start1 = 1'b0; key1 = '0;
    clr();
    #1;
    chk("rst_done", done0, 0);
    chk("rst_match", match0, 0);
    chk("rst_idx", idx0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_req", req0, 0);
    chk("rst_addr", addr0, 0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);

    // full miss, zero-wait memory
    do_run(32'hDEAD_BEEF, -1, '0, -10, n);
    chk("miss_latency", n, 33);
    chk("miss_match", match0, 0);
    chk("miss_idx", idx0, 16);
    chk("miss_reads", rd_cnt, 16);
    chk("miss_seq", seq_err, 0);
    chk("miss_busy", busy0, 0);
    // start held high: no rerun
    idle_cycles(10);
    chk("hold_reads", rd_cnt, 16);
    chk("hold_busy", busy0, 0);
    chk("hold_done", done0, 1);
    start0 = 1'b0; idle_cycles(1);

    // hit at word 5 (also checks done clears on re-launch)
    mem[5] = 32'hCAFE_F00D; clr();
    do_run(32'hCAFE_F00D, -1, '0, -10, n);
    chk("hit_latency", n, 13);
    chk("hit_match", match0, 1);
    chk("hit_idx", idx0, 5);
    chk("hit_reads", rd_cnt, 6);
    chk("hit_no_18", seen18, 0);
    start0 = 1'b0; idle_cycles(1);

    // same hit with stalled grant and response
    gdly = 3; rdly = 2; clr();
    do_run(32'hCAFE_F00D, -1, '0, -10, n);
    chk("stall_match", match0, 1);
    chk("stall_idx", idx0, 5);
    chk("stall_reads", rd_cnt, 6);
    chk("stall_stable", stall_err, 0);
    chk("stall_outst", ost_err, 0);
    chk("stall_seq", seq_err, 0);
    start0 = 1'b0; gdly = 0; rdly = 0; idle_cycles(1);

    // key changed mid-run: latched key wins
    mem[1] = 32'h1111_2222; mem[3] = 32'hAAAA_5555; clr();
    do_run(32'hAAAA_5555, 2, 32'h1111_2222, -10, n);
    chk("keychg_idx", idx0, 3);
    chk("keychg_match", match0, 1);
    chk("keychg_reads", rd_cnt, 4);
    start0 = 1'b0; idle_cycles(1);

    // second start edge while busy is ignored
    clr();
    do_run(32'hDEAD_BEEF, -1, '0, 5, n);
    chk("edge2_latency", n, 33);
    chk("edge2_reads", rd_cnt, 16);
    chk("edge2_idx", idx0, 16);
    start0 = 1'b0; idle_cycles(1);

    // NumWords=1 hit and miss
    mem1w = 32'h0000_0055;
    run1(32'h0000_0055, n);
    chk("nw1_hit_match", match1, 1);
    chk("nw1_hit_idx", idx1, 0);
    chk("nw1_hit_reads", rd1_cnt, 1);
    idle_cycles(1);
    run1(32'h0000_0066, n);
    chk("nw1_miss_match", match1, 0);
    chk("nw1_miss_idx", idx1, 1);
    chk("nw1_done", done1, 1);
    idle_cycles(1);

    // reset while in WAIT, late rvalid after release
    rdly = 4; clr();
    start0 = 1'b1; key0 = 32'hDEAD_BEEF; n = 0;
    do begin @(posedge clk); #1; n++; end while (rd_cnt < 1 && n < 50);
    chk("rst_reach_wait", rd_cnt, 1);
    rst_n = 1'b0; #1;
    chk("rst_req_async", req0, 0);
    chk("rst_busy_async", busy0, 0);
    idle_cycles(1);
    rst_n = 1'b1;
    bad_out = 0;
    for (int i = 0; i < 8; i++) begin
      idle_cycles(1);
      if (done0 || busy0 || req0 || match0 || idx0 != 0) bad_out++;
    end
    chk("rst_late_rv_seen", rv_seen, 1);
    chk("rst_quiet", bad_out, 0);
    start0 = 1'b0; rdly = 0; idle_cycles(1);
    clr();
    do_run(32'hDEAD_BEEF, -1, '0, -10, n);
    chk("post_rst_latency", n, 33);
    chk("post_rst_idx", idx0, 16);
    chk("post_rst_reads", rd_cnt, 16);
    start0 = 1'b0; idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
